// File: rtl/jtag_reg_access_pkg.sv
// Shared register-file definitions plus the JTAG register-access retry limit and FSM encodings.
// Used by jtag_reg_access (optional readback: define JTAG_REG_READBACK_EN).
package jtag_reg_access_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegBus     = 32;

    localparam logic [RegAddrBus-1:0] ZeroReg     = '0;
    localparam logic [RegBus-1:0]     ZeroWord    = '0;
    localparam logic                  WriteEnable = 1'b1;

    // Extra attempts after a collided access; legal range 1..15 (fits the 4-bit counter).
    localparam int JtagRetryMax = 4;
    localparam int JtagCntW     = 4;

    typedef enum logic [1:0] {
        JTAG_IDLE  = 2'b00,
        JTAG_WRITE = 2'b01,
        JTAG_READ  = 2'b10,
        JTAG_RESP  = 2'b11
    } jtag_state_e;

endpackage

// File: rtl/jtag_reg_access_if.sv
// Command/response, register-file JTAG port and ex-stage monitor signals of jtag_reg_access.
// slave = the access block; master = the DM / register-file side that drives it.
interface jtag_reg_access_if
    import jtag_reg_access_pkg::*;
#(
    parameter int ADDR_W = RegAddrBus,
    parameter int DATA_W = RegBus
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    logic              reg_we_o;
    logic [ADDR_W-1:0] reg_addr_o;
    logic [DATA_W-1:0] reg_wdata_o;
    logic [DATA_W-1:0] reg_rdata_i;

    logic              core_we_i;
    logic [ADDR_W-1:0] core_waddr_i;

    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  rsp_ready_i, reg_rdata_i, core_we_i, core_waddr_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output reg_we_o, reg_addr_o, reg_wdata_o
    );

    modport master (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output rsp_ready_i, reg_rdata_i, core_we_i, core_waddr_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  reg_we_o, reg_addr_o, reg_wdata_o
    );

endinterface

// File: rtl/jtag_reg_access.sv
// JTAG-side register-file initiator: one command at a time, retries accesses that collide with ex-stage writes.
// Optional: define JTAG_REG_READBACK_EN to read back every non-zero write and flag a mismatch.
module jtag_reg_access
    import jtag_reg_access_pkg::*;
#(
    parameter int ADDR_W    = RegAddrBus,
    parameter int DATA_W    = RegBus,
    parameter int MAX_RETRY = JtagRetryMax
) (
    input logic              clk,
    input logic              rst,
    jtag_reg_access_if.slave bus
);

    jtag_state_e         state_q, state_d;
    logic [JtagCntW-1:0] cnt_q, cnt_d;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                accept;

    logic                core_hit_any;
    logic                core_hit_addr;
    logic                retry_left;
    logic [DATA_W-1:0]   sample;

    // Any ex write to a non-zero register wins the write port; only a same-register write makes a read stale.
    assign core_hit_any  = bus.core_we_i && (bus.core_waddr_i != '0);
    assign core_hit_addr = core_hit_any && (bus.core_waddr_i == addr_q);
    assign retry_left    = (cnt_q != JtagCntW'(MAX_RETRY));
    assign sample        = (addr_q == '0) ? '0 : bus.reg_rdata_i;

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;

        case (state_q)
            JTAG_IDLE: begin
                if (bus.cmd_valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (!bus.cmd_write_i) begin
                        state_d = JTAG_READ;
                    end else if (bus.cmd_addr_i == '0) begin
                        state_d = JTAG_RESP;
                    end else begin
                        state_d = JTAG_WRITE;
                    end
                end
            end

            JTAG_WRITE: begin
                if (core_hit_any) begin
                    if (retry_left) begin
                        cnt_d = cnt_q + JtagCntW'(1);
                    end else begin
                        err_d   = 1'b1;
                        state_d = JTAG_RESP;
                    end
                end else begin
`ifdef JTAG_REG_READBACK_EN
                    cnt_d   = '0;
                    state_d = JTAG_READ;
`else
                    state_d = JTAG_RESP;
`endif
                end
            end

            JTAG_READ: begin
                if (core_hit_addr) begin
                    if (retry_left) begin
                        cnt_d = cnt_q + JtagCntW'(1);
                    end else begin
                        err_d   = 1'b1;
                        state_d = JTAG_RESP;
                    end
                end else begin
                    rdata_d = sample;
                    // Only a readback (write command) can mismatch; plain reads never flag.
                    err_d   = wr_q && (sample != wdata_q);
                    state_d = JTAG_RESP;
                end
            end

            JTAG_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = JTAG_IDLE;
                end
            end

            default: state_d = JTAG_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= JTAG_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= bus.cmd_write_i;
                addr_q  <= bus.cmd_addr_i;
                wdata_q <= bus.cmd_wdata_i;
            end
        end
    end

    assign bus.cmd_ready_o = (state_q == JTAG_IDLE);
    assign bus.rsp_valid_o = (state_q == JTAG_RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.reg_we_o    = (state_q == JTAG_WRITE) ? WriteEnable : ~WriteEnable;
    assign bus.reg_addr_o  = addr_q;
    assign bus.reg_wdata_o = wdata_q;

endmodule
